// File: rtl/serial_nibble_deser_if.sv
// Serial-in / parallel-out bus for serial_nibble_deser.
// Ports (signals):
//   i_sdata, i_svalid, i_sof : serial bit, bit-valid, start-of-frame (toward the deserializer)
//   o_a[WIDTH-1:0], o_en     : assembled word and latch enable for the nibble-reversal stage
//   o_busy, o_err            : frame in progress, single-cycle error pulse
// Modports: master drives the serial side, slave is the deserializer.
interface serial_nibble_deser_if #(
   parameter int unsigned WIDTH = 4
);
   logic             i_sdata;
   logic             i_svalid;
   logic             i_sof;
   logic [WIDTH-1:0] o_a;
   logic             o_en;
   logic             o_busy;
   logic             o_err;

   modport master (
      output i_sdata, i_svalid, i_sof,
      input  o_a, o_en, o_busy, o_err
   );

   modport slave (
      input  i_sdata, i_svalid, i_sof,
      output o_a, o_en, o_busy, o_err
   );
endinterface

// File: rtl/serial_nibble_deser.sv
// Bit-serial to parallel deserializer feeding the nibble-reversal stage.
// Collects WIDTH bits per frame (i_sof marks bit 0) and presents the word on
// o_a together with a registered enable o_en held for EN_CYCLES cycles.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : serial_nibble_deser_if.slave (i_sdata/i_svalid/i_sof in,
//             o_a/o_en/o_busy/o_err out)
// Optional feature: define SERIAL_NIBBLE_DESER_PARITY_EN to require an
// even-parity bit after the data bits (PAR state).
module serial_nibble_deser #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned EN_CYCLES = 1,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   serial_nibble_deser_if.slave bus
);

   localparam int unsigned    CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [3:0]     HOLD_INIT = 4'(EN_CYCLES - 1);

`ifdef SERIAL_NIBBLE_DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] sr, sr_n, word;
   logic [CW-1:0]    cnt, cnt_n;
   logic [3:0]       hold_cnt, hold_n;
   logic [WIDTH-1:0] a_q, a_n;
   logic             en_q, en_n;
   logic             err_q, err_n;

   // Shifting in from the LSB end leaves bit 0 at the MSB after WIDTH bits;
   // shifting in from the MSB end leaves bit 0 at index 0.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic b);
      if (MSB_FIRST)
         shift_in = {cur[WIDTH-2:0], b};
      else
         shift_in = {b, cur[WIDTH-1:1]};
   endfunction

   always_comb begin
      state_n = state;
      sr_n    = sr;
      cnt_n   = cnt;
      hold_n  = hold_cnt;
      a_n     = a_q;
      en_n    = 1'b0;
      err_n   = 1'b0;
      word    = shift_in(sr, bus.i_sdata);

      unique case (state)
         IDLE: begin
            if (bus.i_svalid && bus.i_sof) begin
               sr_n    = shift_in('0, bus.i_sdata);
               cnt_n   = CW'(1);
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.i_svalid) begin
               if (bus.i_sof) begin
                  // Framing error: drop partial word, this bit restarts the frame.
                  err_n = 1'b1;
                  sr_n  = shift_in('0, bus.i_sdata);
                  cnt_n = CW'(1);
               end else if (cnt == LAST_BIT) begin
                  sr_n  = word;
                  cnt_n = '0;
`ifdef SERIAL_NIBBLE_DESER_PARITY_EN
                  state_n = PAR;
`else
                  a_n     = word;
                  en_n    = 1'b1;
                  hold_n  = HOLD_INIT;
                  state_n = HOLD;
`endif
               end else begin
                  sr_n  = word;
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         HOLD: begin
            // Bits arriving while the word is presented are dropped.
            if (bus.i_svalid)
               err_n = 1'b1;
            if (hold_cnt != 4'd0) begin
               en_n   = 1'b1;
               hold_n = hold_cnt - 4'd1;
            end else begin
               state_n = IDLE;
            end
         end
`ifdef SERIAL_NIBBLE_DESER_PARITY_EN
         PAR: begin
            if (bus.i_svalid) begin
               if (bus.i_sof) begin
                  err_n   = 1'b1;
                  sr_n    = shift_in('0, bus.i_sdata);
                  cnt_n   = CW'(1);
                  state_n = SHIFT;
               end else if ((^sr) == bus.i_sdata) begin
                  a_n     = sr;
                  en_n    = 1'b1;
                  hold_n  = HOLD_INIT;
                  state_n = HOLD;
               end else begin
                  err_n   = 1'b1;
                  state_n = IDLE;
               end
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         hold_cnt <= '0;
         a_q      <= '0;
         en_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         sr       <= sr_n;
         cnt      <= cnt_n;
         hold_cnt <= hold_n;
         a_q      <= a_n;
         en_q     <= en_n;
         err_q    <= err_n;
      end
   end

   assign bus.o_a    = a_q;
   assign bus.o_en   = en_q;
   assign bus.o_err  = err_q;
   assign bus.o_busy = (state != IDLE);

endmodule

// File: tb/tb_serial_nibble_deser.sv
// Bench for serial_nibble_deser: two instances share one serial stream,
// dut0 (MSB_FIRST=1, EN_CYCLES=1) and dut1 (MSB_FIRST=0, EN_CYCLES=3).
// Stimulus pushes hand-computed words and error-pulse edges into per-DUT
// queues; a negedge monitor pops and compares as outputs appear.
module tb_serial_nibble_deser;

   typedef struct {
      logic [3:0] w;
      int         edge_n;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_pass;

   exp_t exp_q[2][$];
   int   err_q[2][$];

   logic [3:0] a_s[2];
   logic       en_s[2], err_s[2], busy_s[2];
   logic       prev_en[2];
   logic [3:0] held[2];
   int         en_len[2];

   serial_nibble_deser_if #(.WIDTH(4)) if0 ();
   serial_nibble_deser_if #(.WIDTH(4)) if1 ();

   serial_nibble_deser #(.WIDTH(4), .EN_CYCLES(1), .MSB_FIRST(1'b1)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave)
   );
   serial_nibble_deser #(.WIDTH(4), .EN_CYCLES(3), .MSB_FIRST(1'b0)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave)
   );

   assign a_s[0] = if0.o_a;  assign en_s[0] = if0.o_en;
   assign err_s[0] = if0.o_err;  assign busy_s[0] = if0.o_busy;
   assign a_s[1] = if1.o_a;  assign en_s[1] = if1.o_en;
   assign err_s[1] = if1.o_err;  assign busy_s[1] = if1.o_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int en_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string nm, input int d, input int act, input int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, d, act, exp_v, $time);
   endtask

   task automatic drive(input logic v, input logic s, input logic b);
      if0.i_svalid = v; if0.i_sof = s; if0.i_sdata = b;
      if1.i_svalid = v; if1.i_sof = s; if1.i_sdata = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   // Word appears after the edge that samples the next driven bit.
   task automatic push_word(input logic [3:0] wm, input logic [3:0] wl);
      exp_q[0].push_back('{w: wm, edge_n: cyc + 1});
      exp_q[1].push_back('{w: wl, edge_n: cyc + 1});
   endtask

   task automatic push_err();
      err_q[0].push_back(cyc + 1);
      err_q[1].push_back(cyc + 1);
   endtask

   // seq[3] is the first bit on the wire; wm/wl are the expected MSB-first
   // and LSB-first words.
   task automatic send_frame(input logic [3:0] seq, input logic [3:0] wm,
                             input logic [3:0] wl);
      for (int i = 3; i > 0; i--) drive(1'b1, (i == 3), seq[i]);
`ifdef SERIAL_NIBBLE_DESER_PARITY_EN
      drive(1'b1, 1'b0, seq[0]);
      push_word(wm, wl);
      drive(1'b1, 1'b0, ^seq);
`else
      push_word(wm, wl);
      drive(1'b1, 1'b0, seq[0]);
`endif
   endtask

`ifdef SERIAL_NIBBLE_DESER_PARITY_EN
   task automatic send_bad_par(input logic [3:0] seq);
      for (int i = 3; i >= 0; i--) drive(1'b1, (i == 3), seq[i]);
      push_err();
      drive(1'b1, 1'b0, ~^seq);
   endtask
`endif

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            held[d] = 4'b0000;
            prev_en[d] = 1'b0;
            en_len[d] = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (en_s[d] && !prev_en[d]) begin
               if (exp_q[d].size() == 0) begin
                  chk("o_en_unexpected", d, 1, 0);
               end else begin
                  e = exp_q[d].pop_front();
                  chk("o_a_word", d, int'(a_s[d]), int'(e.w));
                  chk("o_en_rise_edge", d, cyc, e.edge_n);
               end
               held[d] = a_s[d];
               en_len[d] = 1;
            end else begin
               chk("o_a_hold", d, int'(a_s[d]), int'(held[d]));
               if (en_s[d]) en_len[d]++;
               else if (prev_en[d]) begin
                  chk("o_en_width", d, en_len[d], en_of(d));
                  chk("o_busy_after_hold", d, int'(busy_s[d]), 0);
               end
            end
            if (err_s[d]) begin
               if (err_q[d].size() == 0) chk("o_err_unexpected", d, 1, 0);
               else chk("o_err_edge", d, cyc, err_q[d].pop_front());
            end
            prev_en[d] = en_s[d];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      if0.i_svalid = 1'b0; if0.i_sof = 1'b0; if0.i_sdata = 1'b0;
      if1.i_svalid = 1'b0; if1.i_sof = 1'b0; if1.i_sdata = 1'b0;
      @(posedge clk);
      #1;
      idle(2);
      for (int d = 0; d < 2; d++) begin
         chk("reset_o_a", d, int'(a_s[d]), 0);
         chk("reset_o_en", d, int'(en_s[d]), 0);
         chk("reset_o_err", d, int'(err_s[d]), 0);
         chk("reset_o_busy", d, int'(busy_s[d]), 0);
      end
      rst_n = 1'b1;
      idle(2);

      // Basic capture: 1,0,1,1
      send_frame(4'b1011, 4'b1011, 4'b1101);
      idle(5);

      // Reset after two bits of a frame
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("midframe_reset_o_a", d, int'(a_s[d]), 0);
         chk("midframe_reset_o_busy", d, int'(busy_s[d]), 0);
      end
      @(posedge clk);
      #1;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      send_frame(4'b1011, 4'b1011, 4'b1101);
      idle(5);

      // Another pattern: 0,0,1,0
      send_frame(4'b0010, 4'b0010, 4'b0100);
      idle(5);

      // Gaps, then i_sof mid-frame restarts: 0,1,1,1
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      idle(5);
      push_err();
      send_frame(4'b0111, 4'b0111, 4'b1110);
      idle(5);

      // Bit (with i_sof) arriving while o_en is high is dropped
      send_frame(4'b1100, 4'b1100, 4'b0011);
      push_err();
      drive(1'b1, 1'b1, 1'b1);
      idle(5);
      send_frame(4'b1001, 4'b1001, 4'b1001);

      // Back-to-back: next i_sof at the first IDLE cycle of the EN_CYCLES=3 instance
      idle(3);
      send_frame(4'b1110, 4'b1110, 4'b0111);
      idle(3);
      send_frame(4'b0101, 4'b0101, 4'b1010);
      idle(5);

`ifdef SERIAL_NIBBLE_DESER_PARITY_EN
      // Bad parity: error pulse, no o_en, o_a keeps 0101 / 1010
      send_bad_par(4'b1011);
      idle(5);
      send_frame(4'b1011, 4'b1011, 4'b1101);
      idle(5);
`endif

      idle(10);
      for (int d = 0; d < 2; d++) begin
         chk("pending_words", d, exp_q[d].size(), 0);
         chk("pending_errs", d, err_q[d].size(), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
